// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction fetch front end with an in-order prefetch FIFO.
// Issues credit-limited fetch requests, tags each returned word with its PC,
// queues it for decode, and on a branch/jump redirect flushes the queue and
// discards responses that are still in flight.
// Optional build macro: IF_BRJ_BYPASS_EN. When it is defined, the redirect
// target is fetched in the same cycle as brj_i.
module if_prefetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  brj_i,
   input  logic [DATA_WIDTH-1:0] brj_pc_i,
   output logic                  instr_req_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [DATA_WIDTH-1:0] instr_rdata_i,
   output logic                  d_valid_o,
   input  logic                  d_ready_i,
   output logic [DATA_WIDTH-1:0] d_instruction_o,
   output logic [DATA_WIDTH-1:0] d_pc_o,
   output logic [DATA_WIDTH-1:0] d_pc4_o,
   output logic                  flush_inst_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
   localparam logic [CNT_W:0]        DEPTH_W = (CNT_W+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] resp_pc;
   logic [DATA_WIDTH-1:0] brj_target;
   logic [DATA_WIDTH-1:0] fetch_addr;
   logic [DATA_WIDTH-1:0] last_pc;
   logic [DATA_WIDTH-1:0] last_pc4;
   logic [DATA_WIDTH-1:0] head_instr;
   logic [DATA_WIDTH-1:0] head_pc;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      discard;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W:0]        credit_used;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];

   logic rsp_ok;
   logic rsp_drop;
   logic push;
   logic pop;
   logic grant;

   // Redirect target is word aligned; masking keeps every input bit in use.
   assign brj_target = brj_pc_i & ~DATA_WIDTH'(3);

   // A response only counts if something is actually in flight.
   assign rsp_ok   = instr_rvalid_i && (outstanding != '0);
   assign rsp_drop = rsp_ok && (discard != '0);
   assign push     = rsp_ok && (discard == '0) && !brj_i;

   assign head_instr = fifo_instr[rd_ptr];
   assign head_pc    = fifo_pc[rd_ptr];

   assign d_valid_o    = (fifo_count != '0) && !brj_i;
   assign pop          = d_valid_o && d_ready_i;
   assign flush_inst_o = !brj_i;

   // Request generation: never ask for more words than the FIFO can hold,
   // counting both queued words and words still in flight.
`ifdef IF_BRJ_BYPASS_EN
   always_comb begin
      credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
      fetch_addr  = pc;
      if (brj_i) begin
         // The queue is being flushed this cycle, so only in-flight words use credit.
         credit_used = {1'b0, outstanding};
         fetch_addr  = brj_target;
      end
      instr_req_o = rst_n && (credit_used < DEPTH_W);
   end
`else
   always_comb begin
      credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
      fetch_addr  = pc;
      instr_req_o = rst_n && !brj_i && (credit_used < DEPTH_W);
   end
`endif

   assign instr_addr_o = fetch_addr[ADDR_WIDTH-1:0];
   assign grant        = instr_req_o && instr_gnt_i;

   // Fetch PC: redirect wins over the normal +4 advance on grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (brj_i) begin
`ifdef IF_BRJ_BYPASS_EN
         pc <= grant ? brj_target + PC_STEP : brj_target;
`else
         pc <= brj_target;
`endif
      end else if (grant) begin
         pc <= pc + PC_STEP;
      end
   end

   // Response PC tag follows accepted (queued) responses only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      resp_pc <= RESET_PC;
      else if (brj_i)  resp_pc <= brj_target;
      else if (push)   resp_pc <= resp_pc + PC_STEP;
   end

   // In-flight request counter: grant adds one, any valid response removes one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         case ({grant, rsp_ok})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Stale-response counter: everything in flight at a redirect (except a
   // response arriving in that same cycle) belongs to the old path. A grant in
   // the redirect cycle is already for the target, so it is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        discard <= '0;
      else if (brj_i)    discard <= outstanding - CNT_W'(rsp_ok);
      else if (rsp_drop) discard <= discard - CNT_W'(1);
   end

   // FIFO pointers and occupancy; a redirect empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (brj_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= instr_rdata_i;
         fifo_pc[wr_ptr]    <= resp_pc;
      end
   end

   // Remember the last PCs shown to decode so they hold while the queue is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_pc  <= '0;
         last_pc4 <= '0;
      end else if (d_valid_o) begin
         last_pc  <= head_pc;
         last_pc4 <= head_pc + PC_STEP;
      end
   end

   // Decode outputs: FIFO head when valid, NOP and held PCs otherwise.
   always_comb begin
      d_instruction_o = NOP;
      d_pc_o          = last_pc;
      d_pc4_o         = last_pc4;
      if (d_valid_o) begin
         d_instruction_o = head_instr;
         d_pc_o          = head_pc;
         d_pc4_o         = head_pc + PC_STEP;
      end
   end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: directed test of if_prefetch_unit with a one-cycle
// memory model and a scoreboard of expected decode words.
module tb_if_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        brj_i;
   logic [31:0] brj_pc_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        d_valid_o;
   logic        d_ready_i;
   logic [31:0] d_instruction_o;
   logic [31:0] d_pc_o;
   logic [31:0] d_pc4_o;
   logic        flush_inst_o;

   always #5 clk = ~clk;

   if_prefetch_unit #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .brj_i(brj_i), .brj_pc_i(brj_pc_i),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
      .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
      .d_instruction_o(d_instruction_o), .d_pc_o(d_pc_o), .d_pc4_o(d_pc4_o),
      .flush_inst_o(flush_inst_o)
   );

   typedef struct { logic [31:0] addr; bit stale; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   pend_t       pend[$];
   exp_t        expq[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_grant  = 0;
   int          g0;
   bit          mem_en;
   bit          spur;
   bit          mark;
   logic [31:0] first_pc;
   logic [31:0] base;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge (scoreboard + memory bookkeeping), then
   // drive the memory response for the next cycle just after posedge.
   task automatic cyc();
      pend_t p;
      exp_t  e;
      @(negedge clk);
      if (rst_n) begin
         if (d_valid_o && d_ready_i) begin
            chk("pop_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("pop_pc", d_pc_o, e.pc);
               chk("pop_pc4", d_pc4_o, e.pc + 32'd4);
               chk("pop_instr", d_instruction_o, e.instr);
            end
            if (mark) begin
               first_pc = d_pc_o;
               mark = 1'b0;
            end
         end
         if (instr_rvalid_i && pend.size() != 0) begin
            p = pend.pop_front();
            if (!p.stale && !brj_i) expq.push_back('{p.addr, mem_word(p.addr)});
         end
         if (brj_i) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            expq.delete();
         end
         if (instr_req_o && instr_gnt_i) begin
            pend.push_back('{instr_addr_o, 1'b0});
            n_grant++;
         end
      end
      @(posedge clk);
      #1;
      if (spur) begin
         instr_rvalid_i = 1'b1;
         instr_rdata_i  = 32'hBAD0_BAD0;
      end else if (rst_n && mem_en && pend.size() != 0) begin
         instr_rvalid_i = 1'b1;
         instr_rdata_i  = mem_word(pend[0].addr);
      end else begin
         instr_rvalid_i = 1'b0;
         instr_rdata_i  = 32'h0;
      end
   endtask

   initial begin
      rst_n = 1'b0; brj_i = 1'b0; brj_pc_i = 32'h0; instr_gnt_i = 1'b0;
      instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; d_ready_i = 1'b1;
      mem_en = 1'b1; spur = 1'b0; mark = 1'b0; first_pc = 32'h0;

      // Reset values
      #3;
      chk("rst_req", 32'(instr_req_o), 32'd0);
      chk("rst_dvalid", 32'(d_valid_o), 32'd0);
      chk("rst_instr", d_instruction_o, 32'h13);
      chk("rst_pc", d_pc_o, 32'h0);
      chk("rst_pc4", d_pc4_o, 32'h0);
      chk("rst_flush", 32'(flush_inst_o), 32'd1);

      // Streaming after release: first fetch in cycle 0, first decode in cycle 2
      repeat (2) @(posedge clk);
      #1; instr_gnt_i = 1'b1; rst_n = 1'b1;
      #1;
      chk("c0_req", 32'(instr_req_o), 32'd1);
      chk("c0_addr", instr_addr_o, 32'h0);
      chk("c0_dvalid", 32'(d_valid_o), 32'd0);
      cyc(); #1;
      chk("c1_dvalid", 32'(d_valid_o), 32'd0);
      chk("c1_addr", instr_addr_o, 32'h4);
      cyc(); #1;
      chk("c2_dvalid", 32'(d_valid_o), 32'd1);
      chk("c2_pc", d_pc_o, 32'h0);
      chk("c2_pc4", d_pc4_o, 32'h4);
      repeat (6) cyc();

      // Decode stall: exactly FIFO_DEPTH grants, head held
      instr_gnt_i = 1'b0;
      repeat (6) cyc();
      base = 32'(n_grant) * 32'd4;
      instr_gnt_i = 1'b1; d_ready_i = 1'b0; g0 = n_grant;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (i >= 2) chk("stall_hold_pc", d_pc_o, base);
         cyc();
      end
      #1;
      chk("stall_grants", 32'(n_grant - g0), 32'd4);
      chk("stall_req", 32'(instr_req_o), 32'd0);
      chk("stall_dvalid", 32'(d_valid_o), 32'd1);
      chk("stall_instr", d_instruction_o, mem_word(base));
      d_ready_i = 1'b1; instr_gnt_i = 1'b0;
      repeat (6) cyc();
      chk("stall_drained", 32'(expq.size()), 32'd0);

      // Redirect with two responses in flight
      instr_gnt_i = 1'b1; mem_en = 1'b0;
      cyc(); cyc();
      brj_i = 1'b1; brj_pc_i = 32'h103; mark = 1'b1;
      #1;
`ifdef IF_BRJ_BYPASS_EN
      chk("brj_req", 32'(instr_req_o), 32'd1);
      chk("brj_addr", instr_addr_o, 32'h100);
`else
      chk("brj_req", 32'(instr_req_o), 32'd0);
`endif
      chk("brj_dvalid", 32'(d_valid_o), 32'd0);
      chk("brj_flush", 32'(flush_inst_o), 32'd0);
      cyc();
      brj_i = 1'b0; mem_en = 1'b1;
      #1;
`ifdef IF_BRJ_BYPASS_EN
      chk("post_brj_addr", instr_addr_o, 32'h104);
`else
      chk("post_brj_addr", instr_addr_o, 32'h100);
`endif
      repeat (8) cyc();
      chk("brj_first_pc", first_pc, 32'h100);

      // Spurious response with nothing in flight
      instr_gnt_i = 1'b0;
      repeat (6) cyc();
      spur = 1'b1;
      cyc();
      spur = 1'b0;
      #1;
      chk("spur_dvalid0", 32'(d_valid_o), 32'd0);
      cyc(); #1;
      chk("spur_dvalid1", 32'(d_valid_o), 32'd0);
      chk("spur_req", 32'(instr_req_o), 32'd1);

      // Back-to-back redirects to the top of memory, then wrap to 0
      instr_gnt_i = 1'b1; mem_en = 1'b0;
      cyc(); cyc();
      brj_i = 1'b1; brj_pc_i = 32'hFFFF_FFFC;
      cyc();
      brj_pc_i = 32'hFFFF_FFFE; mark = 1'b1;
      cyc();
      brj_i = 1'b0; mem_en = 1'b1;
      #1;
`ifdef IF_BRJ_BYPASS_EN
      chk("wrap_addr0", instr_addr_o, 32'h0);
      cyc();
`else
      chk("wrap_addr0", instr_addr_o, 32'hFFFF_FFFC);
      cyc(); #1;
      chk("wrap_addr1", instr_addr_o, 32'h0);
`endif
      repeat (8) cyc();
      chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);

      // Reset with requests in flight and a partly full FIFO
      instr_gnt_i = 1'b0;
      repeat (6) cyc();
      d_ready_i = 1'b0; instr_gnt_i = 1'b1; mem_en = 1'b1;
      cyc(); cyc();
      mem_en = 1'b0;
      cyc(); cyc();
      chk("pre_rst_dvalid", 32'(d_valid_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 32'(instr_req_o), 32'd0);
      chk("mid_rst_dvalid", 32'(d_valid_o), 32'd0);
      chk("mid_rst_instr", d_instruction_o, 32'h13);
      chk("mid_rst_pc", d_pc_o, 32'h0);
      chk("mid_rst_pc4", d_pc4_o, 32'h0);
      pend.delete(); expq.delete();
      instr_rvalid_i = 1'b0; instr_gnt_i = 1'b0; d_ready_i = 1'b1; mem_en = 1'b1;
      cyc(); cyc();
      rst_n = 1'b1;
      instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_0000;
      #1;
      chk("rel_req", 32'(instr_req_o), 32'd1);
      chk("rel_addr", instr_addr_o, 32'h0);
      cyc(); #1;
      chk("late_rvalid_dvalid", 32'(d_valid_o), 32'd0);
      chk("late_rvalid_req", 32'(instr_req_o), 32'd1);
      instr_gnt_i = 1'b1; mark = 1'b1;
      repeat (6) cyc();
      chk("rel_first_pc", first_pc, 32'h0);
      instr_gnt_i = 1'b0;
      repeat (6) cyc();
      chk("final_expq_empty", 32'(expq.size()), 32'd0);
      chk("final_pend_empty", 32'(pend.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
